// File: rtl/booth_ctrl.sv
// booth_ctrl
//   Sequencer for a radix-2 Booth multiplier datapath. It captures a pair of
//   N-bit operands on start, clears and loads the datapath, runs exactly N
//   evaluate/shift iterations, then registers the 2N-bit product and pulses
//   done for one cycle.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   start             multiply request, only looked at in IDLE
//   a_in, b_in        multiplicand / multiplier, captured when start is accepted
//   q_lsb             {LQ[0], Q_1} Booth pair from the datapath
//   y                 {HQ, LQ} product bus from the datapath
//   dp_a, dp_b        captured operands presented to the datapath
//   dp_rst            one-cycle datapath clear (ORed with rst at the top level)
//   load_A, load_B    load operand registers
//   load_add, add_sub accumulate HQ +/- A (add_sub=1 adds)
//   shift_HQ_LQ_Q_1   arithmetic right shift of {HQ, LQ, Q_1}
//   busy              high in every state except IDLE
//   done              registered one-cycle pulse, product valid
//   product           registered result, held until the next DONE
//
// state | meaning
// IDLE  | waiting for start; operands captured on acceptance
// CLEAR | dp_rst pulse to clear the datapath
// LOAD  | load A and B, clear iteration counter
// EVAL  | decode Booth pair, optionally add/subtract A into HQ
// SHIFT | shift {HQ, LQ, Q_1}, count the iteration
// DONE  | register product; done rises on the following edge

module booth_ctrl #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     a_in,
  input  logic [N-1:0]     b_in,
  input  logic [1:0]       q_lsb,
  input  logic [2*N-1:0]   y,
  output logic [N-1:0]     dp_a,
  output logic [N-1:0]     dp_b,
  output logic             dp_rst,
  output logic             load_A,
  output logic             load_B,
  output logic             load_add,
  output logic             shift_HQ_LQ_Q_1,
  output logic             add_sub,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   product
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    EVAL  = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic [N-1:0]     dp_a_q, dp_a_d;
  logic [N-1:0]     dp_b_q, dp_b_d;
  logic [2*N-1:0]   product_q, product_d;
  logic             done_q, done_d;

  assign cnt_inc = cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dp_a_q    <= '0;
      dp_b_q    <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dp_a_q    <= dp_a_d;
      dp_b_q    <= dp_b_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    dp_a_d          = dp_a_q;
    dp_b_d          = dp_b_q;
    product_d       = product_q;
    done_d          = 1'b0;
    dp_rst          = 1'b0;
    load_A          = 1'b0;
    load_B          = 1'b0;
    load_add        = 1'b0;
    add_sub         = 1'b0;
    shift_HQ_LQ_Q_1 = 1'b0;

    case (state_q)
      IDLE: begin
        // done_q may be high here; accepting start in that cycle gives
        // back-to-back operation without an extra idle cycle.
        if (start) begin
          dp_a_d  = a_in;
          dp_b_d  = b_in;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        dp_rst  = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        load_A  = 1'b1;
        load_B  = 1'b1;
        cnt_d   = '0;
        state_d = EVAL;
      end
      EVAL: begin
        unique case (q_lsb)
          2'b01: begin
            load_add = 1'b1;
            add_sub  = 1'b1;
          end
          2'b10: begin
            load_add = 1'b1;
            add_sub  = 1'b0;
          end
          default: begin
            load_add = 1'b0;
            add_sub  = 1'b0;
          end
        endcase
        state_d = SHIFT;
      end
      SHIFT: begin
        shift_HQ_LQ_Q_1 = 1'b1;
        cnt_d           = cnt_inc;
        // Iteration count is fixed at N regardless of operand values.
        state_d         = (cnt_inc == CNT_LAST) ? DONE : EVAL;
      end
      DONE: begin
        product_d = y;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign dp_a    = dp_a_q;
  assign dp_b    = dp_b_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: a behavioural Booth datapath closes the loop, a
// scoreboard of accepted operations predicts every control output per cycle
// from the operation's phase, and products are checked against a*b.
module tb_booth_ctrl;

  localparam int N   = 8;
  localparam int LAT = 2*N + 3;   // edges from accepting edge to done visible

  logic           clk = 1'b0;
  logic           rst, start;
  logic [N-1:0]   a_in, b_in;
  logic [1:0]     q_lsb;
  logic [2*N-1:0] y;
  logic [N-1:0]   dp_a, dp_b;
  logic           dp_rst, load_A, load_B, load_add, shift_HQ_LQ_Q_1, add_sub;
  logic           busy, done;
  logic [2*N-1:0] product;

  booth_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .q_lsb(q_lsb), .y(y), .dp_a(dp_a), .dp_b(dp_b), .dp_rst(dp_rst),
    .load_A(load_A), .load_B(load_B), .load_add(load_add),
    .shift_HQ_LQ_Q_1(shift_HQ_LQ_Q_1), .add_sub(add_sub),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  // behavioural datapath; HQ carries a guard bit so -2^(N-1) operands work
  logic signed [N:0] m_a, m_hq;
  logic [N-1:0]      m_lq;
  logic              m_q1;
  logic              force_en;
  logic [1:0]        q_force;

  always @(posedge clk) begin
    if (rst || dp_rst) begin
      m_a <= '0; m_hq <= '0; m_lq <= '0; m_q1 <= 1'b0;
    end else begin
      if (load_A)   m_a  <= {dp_a[N-1], dp_a};
      if (load_B)   m_lq <= dp_b;
      if (load_add) m_hq <= add_sub ? m_hq + m_a : m_hq - m_a;
      if (shift_HQ_LQ_Q_1) {m_hq, m_lq, m_q1} <= {m_hq[N], m_hq, m_lq};
    end
  end

  assign y     = {m_hq[N-1:0], m_lq};
  assign q_lsb = force_en ? q_force : {m_lq[0], m_q1};

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int             acc;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           forced;
    logic [2*N-1:0] exp_p;
  } rec_t;

  rec_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  function automatic logic [2*N-1:0] smul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] ax, bx;
    ax = {{N{a[N-1]}}, a};
    bx = {{N{b[N-1]}}, b};
    return ax * bx;
  endfunction

  task automatic push(input logic [N-1:0] a, input logic [N-1:0] b, input logic frc);
    rec_t r;
    r.acc = edge_cnt + 1;
    r.a = a; r.b = b; r.forced = frc;
    r.exp_p = smul(a, b);
    sb.push_back(r);
  endtask

  // monitor / scoreboard
  logic           mon_en = 1'b0;
  logic [2*N-1:0] last_p, y_snap;
  logic [N-1:0]   last_a, last_b;
  int             n_busy, n_shift, ph;
  logic e_busy, e_dprst, e_ldab, e_ladd, e_as, e_sh, e_done;

  always @(negedge clk) begin
    if (mon_en) begin
      e_busy = 0; e_dprst = 0; e_ldab = 0; e_ladd = 0; e_as = 0; e_sh = 0; e_done = 0;
      if (busy) n_busy++;
      if (shift_HQ_LQ_Q_1) n_shift++;
      chk("add_shift_excl", {63'd0, load_add & shift_HQ_LQ_Q_1}, 64'd0);
      if (sb.size() > 0 && edge_cnt >= sb[0].acc) begin
        ph = edge_cnt - sb[0].acc;
        if (ph == 0) begin
          last_a = sb[0].a;
          last_b = sb[0].b;
        end
        e_busy  = (ph <= LAT - 1);
        e_dprst = (ph == 0);
        e_ldab  = (ph == 1);
        if (ph >= 2 && ph <= 2*N + 1) begin
          if (ph % 2 == 0) begin
            e_ladd = (q_lsb == 2'b01) || (q_lsb == 2'b10);
            e_as   = (q_lsb == 2'b01);
          end else begin
            e_sh = 1'b1;
          end
        end
        if (ph == 2*N + 2) y_snap = y;
        if (ph == LAT) begin
          e_done = 1'b1;
          last_p = y_snap;
          if (!sb[0].forced) chk("product_ab", 64'(product), 64'(sb[0].exp_p));
          void'(sb.pop_front());
        end
      end
      chk("busy",     {63'd0, busy},            {63'd0, e_busy});
      chk("dp_rst",   {63'd0, dp_rst},          {63'd0, e_dprst});
      chk("load_A",   {63'd0, load_A},          {63'd0, e_ldab});
      chk("load_B",   {63'd0, load_B},          {63'd0, e_ldab});
      chk("load_add", {63'd0, load_add},        {63'd0, e_ladd});
      chk("add_sub",  {63'd0, add_sub},         {63'd0, e_as});
      chk("shift",    {63'd0, shift_HQ_LQ_Q_1}, {63'd0, e_sh});
      chk("done",     {63'd0, done},            {63'd0, e_done});
      chk("product",  64'(product), 64'(last_p));
      chk("dp_a",     64'(dp_a),    64'(last_a));
      chk("dp_b",     64'(dp_b),    64'(last_b));
    end
  end

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic frc, input logic [1:0] qf, input logic tog);
    force_en = frc;
    q_force  = qf;
    a_in = a; b_in = b; start = 1'b1;
    push(a, b, frc);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (LAT) begin
      if (tog) begin
        a_in = N'($urandom);
        b_in = N'($urandom);
      end
      @(posedge clk); #1;
    end
    force_en = 1'b0;
  endtask

  task automatic clear_expect();
    sb.delete();
    last_p = '0; last_a = '0; last_b = '0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    force_en = 1'b0; q_force = 2'b00;
    last_p = '0; last_a = '0; last_b = '0; y_snap = '0;
    n_busy = 0; n_shift = 0; ph = 0;
    @(posedge clk); #1;
    mon_en = 1'b1;                 // reset values checked while rst is held
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // single 3 x 4 operation: busy and shift pulse counts
    n_busy = 0; n_shift = 0;
    do_op(8'd3, 8'd4, 1'b0, 2'b00, 1'b0);
    @(posedge clk); #1;
    chk("busy_cycles", 64'(n_busy), 64'd19);
    chk("shift_pulses", 64'(n_shift), 64'd8);

    // Booth pair decode with q_lsb forced
    for (int q = 0; q < 4; q++) begin
      do_op(N'($urandom), N'($urandom), 1'b1, 2'(q), 1'b0);
      repeat (2) begin @(posedge clk); #1; end
    end

    // corner operands, then operands toggling during the op
    do_op(8'h80, 8'h80, 1'b0, 2'b00, 1'b0);
    do_op(8'h7f, 8'h80, 1'b0, 2'b00, 1'b0);   // back-to-back acceptance
    do_op(8'hff, 8'h01, 1'b0, 2'b00, 1'b0);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      do_op(N'($urandom), N'($urandom), 1'b0, 2'b00, 1'b1);
      @(posedge clk); #1;
    end

    // start held high for 40 cycles: acceptances only at 0 and 20
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a_in = N'($urandom);
      b_in = N'($urandom);
      if (i == 0 || i == 20) push(a_in, b_in, 1'b0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end

    // reset during the third SHIFT of an op
    a_in = 8'h5a; b_in = 8'hc3; start = 1'b1;
    push(a_in, b_in, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_expect();
    repeat (3) begin @(posedge clk); #1; end
    do_op(8'hf6, 8'h0d, 1'b0, 2'b00, 1'b0);

    repeat (5) begin @(posedge clk); #1; end
    chk("drain", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/booth_ctrl.md
BOOTH_CTRL -- requirements
Module: booth_ctrl

Interface
- REQ-001: Parameter N, default 8, operand width; the iteration counter is $clog2(N)+1 bits.
- REQ-002: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-003: rst  input  1  synchronous, active-high reset, sampled on rising clk.
- REQ-004: start  input  1  request a multiply; sampled only in IDLE.
- REQ-005: a_in  input  N  multiplicand, captured on start acceptance.
- REQ-006: b_in  input  N  multiplier, captured on start acceptance.
- REQ-007: q_lsb  input  2  datapath {LQ[0], Q_1} Booth pair.
- REQ-008: y  input  2N  datapath product bus {HQ, LQ}.
- REQ-009: dp_a / dp_b  output  N each  captured operands driven to datapath A/B.
- REQ-010: dp_rst  output  1  datapath clear pulse; top level ORs it with rst into the datapath reset.
- REQ-011: load_A, load_B, load_add, shift_HQ_LQ_Q_1, add_sub  output  1 each  datapath controls.
- REQ-012: busy  output  1  high whenever state is not IDLE.
- REQ-013: done  output  1  one-cycle registered pulse when product is valid.
- REQ-014: product  output  2N  registered result, held until the next capture.

Function
- REQ-015: The FSM SHALL have states IDLE, CLEAR, LOAD, EVAL, SHIFT and DONE.
- REQ-016: IDLE with start=1 SHALL capture a_in/b_in into dp_a/dp_b and go to CLEAR; start=0 SHALL stay in IDLE.
- REQ-017: CLEAR SHALL assert dp_rst for exactly one cycle, then go to LOAD.
- REQ-018: LOAD SHALL assert load_A and load_B for one cycle, clear the counter to 0, then go to EVAL.
- REQ-019: EVAL SHALL decode q_lsb combinationally:
  - 01: load_add=1, add_sub=1.
  - 10: load_add=1, add_sub=0.
  - 00 or 11: load_add=0, add_sub=0.
  - Next state is always SHIFT.
- REQ-020: SHIFT SHALL assert shift_HQ_LQ_Q_1 for one cycle and increment the counter.
- REQ-021: After SHIFT, a counter value of N SHALL go to DONE; otherwise the FSM SHALL return to EVAL.
- REQ-022: Every N-bit multiply SHALL take exactly N EVAL/SHIFT pairs, independent of operand values.
- REQ-023: DONE SHALL register product<=y and done<=1, then go to IDLE.
- REQ-024: done SHALL be high in the first IDLE cycle after DONE, and low in all other cycles.
- REQ-025: Latency: start sampled at edge t gives done=1 and valid product in cycle t+2N+4 (t+20 for N=8).
- REQ-026: load_add and shift_HQ_LQ_Q_1 SHALL never be high in the same cycle.
- REQ-027: load_A/load_B SHALL be high only in LOAD.
- REQ-028: All datapath controls SHALL be 0 in IDLE, CLEAR and DONE.
- REQ-029: start while busy=1 SHALL be ignored, with no effect on operands, counter or state.
- REQ-030: start in the same cycle done=1 SHALL be accepted, giving back-to-back operation.
- REQ-031: product SHALL change only in DONE; a new start SHALL NOT disturb it before the next DONE.
- REQ-032: Operand changes on a_in/b_in after acceptance SHALL have no effect on the operation in flight.

Reset
- REQ-033: rst=1 SHALL force IDLE and counter=0 at the next edge, from any state including mid-operation.
- REQ-034: Reset values SHALL be 0 for dp_a, dp_b, product, done, busy, dp_rst and all datapath controls.
- REQ-035: An aborted operation SHALL produce no done pulse and SHALL leave product at 0.
- REQ-036: The first start after rst deasserts SHALL be accepted normally.

Verification
- REQ-037: Single op, N=8, a_in=3, b_in=4, start for 1 cycle, bench models y=0x000C:
  - Expected: busy for 19 cycles.
  - Expected: exactly 8 shift pulses.
  - Expected: done at t+20 with product=0x000C.
- REQ-038: Decode, q_lsb forced through 00/01/10/11 during EVAL. Expected (load_add, add_sub):
  - 00 -> (0,0)
  - 01 -> (1,1)
  - 10 -> (1,0)
  - 11 -> (0,0)
  - Expected: no other control active in any case.
- REQ-039: start held high for 40 cycles:
  - Expected: two complete ops, with the second start accepted in the done cycle.
  - Expected: no start accepted mid-op.
  - Expected: dp_a/dp_b change only at acceptance.
- REQ-040: rst asserted in the 3rd SHIFT of an op:
  - Expected: next cycle IDLE, all outputs 0, no done pulse.
  - Expected: a subsequent op completes with correct timing.
- REQ-041: Assertion check over all tests:
  - Never load_add and shift together.
  - dp_rst exactly one cycle per accepted start.
  - done never more than one cycle wide.
- REQ-042: a_in/b_in toggled randomly every cycle during an op:
  - Expected: dp_a/dp_b stable.
  - Expected: captured product equals the y presented in DONE.
